// File: rtl/nes_line_doubler.sv
// nes_line_doubler
//
// Ping-pong line buffer and 2x scaler between the NES PPU pixel stream and the
// VGA output stage. The PPU fills one scanline of 6-bit palette indices into
// the write buffer. At the same time the VGA side reads the other buffer twice,
// once on each of two consecutive VGA rows. Each NES pixel covers two VGA
// columns, and the 512-column window sits centred in the 640-pixel line.
//
// Ports
//   clk        system clock, single domain
//   rst_n      synchronous active-low reset
//   wr_valid   write strobe, wr_index valid
//   wr_index   palette index being written
//   wr_sol     start of line, rewinds the write pointer
//   rd_ce      VGA pixel strobe; rd_x / rd_y sampled when high
//   rd_x       VGA column
//   rd_y       VGA row
//   rd_index   registered palette index for the sampled pixel
//   rd_active  registered: sampled pixel inside window and a line is present
//   line_req   one-cycle pulse asking the PPU for the next line
//   underrun   sticky: swap was due but the write line was incomplete
//   overrun    sticky: a write was dropped because the write buffer was full
//
// Handshake: the write side has no backpressure. Every wr_valid while the
// buffer is not full is accepted in that cycle. While the buffer is full,
// wr_valid is dropped and flagged.

module nes_line_doubler #(
    parameter int           LINE_W    = 256,
    parameter int           H_OFFSET  = 64,
    parameter int           ACTIVE_H  = 640,
    parameter int           ACTIVE_V  = 480,
    parameter logic [5:0]   BLANK_IDX = 6'h0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [5:0]  wr_index,
    input  logic        wr_sol,
    input  logic        rd_ce,
    input  logic [9:0]  rd_x,
    input  logic [9:0]  rd_y,
    output logic [5:0]  rd_index,
    output logic        rd_active,
    output logic        line_req,
    output logic        underrun,
    output logic        overrun
);

    localparam int          AW     = $clog2(LINE_W);
    localparam logic [9:0]  X_LO   = 10'(H_OFFSET);
    localparam logic [9:0]  X_HI   = 10'(H_OFFSET + 2 * LINE_W);
    localparam logic [9:0]  X_LAST = 10'(ACTIVE_H - 1);
    localparam logic [9:0]  Y_MAX  = 10'(ACTIVE_V);
    localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_W - 1);

    // Both line buffers live in one array. The MSB of the address selects
    // the buffer.
    logic [5:0]     mem [0:2*LINE_W-1];

    logic           wsel;
    logic [AW-1:0]  wptr;
    logic           wfull;
    logic           rvalid;

    logic [5:0]     ram_q;
    logic           act_q;

    logic [AW-1:0]  wptr_eff;
    logic           wr_accept;
    logic           wr_last;
    logic           full_now;
    logic           swap_ev;
    logic           win_hit;
    logic [AW-1:0]  raddr;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    always_comb begin
        // A start-of-line rewinds the pointer before any same-cycle write.
        wptr_eff  = (wr_sol && !wfull) ? '0 : wptr;
        wr_accept = wr_valid && !wfull;
        wr_last   = wr_accept && (wptr_eff == LAST_ADDR);
        // A final write landing in the swap cycle still counts as full.
        full_now  = wfull || wr_last;

        swap_ev   = rd_ce && (rd_x == X_LAST) && rd_y[0] && (rd_y < Y_MAX);
        win_hit   = (rd_x >= X_LO) && (rd_x < X_HI) && (rd_y < Y_MAX);
        // Each NES pixel spans two VGA columns.
        raddr     = AW'((rd_x - X_LO) >> 1);
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wsel     <= 1'b0;
            wptr     <= '0;
            wfull    <= 1'b0;
            rvalid   <= 1'b0;
            line_req <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
            act_q    <= 1'b0;
        end else begin
            line_req <= swap_ev;

            if (wr_valid && wfull) begin
                overrun <= 1'b1;
            end

            if (swap_ev && full_now) begin
                wsel   <= ~wsel;
                wfull  <= 1'b0;
                wptr   <= '0;
                rvalid <= 1'b1;
            end else begin
                // A failed swap leaves the write side alone. The reader keeps
                // its old line.
                if (swap_ev) begin
                    underrun <= 1'b1;
                end
                if (wr_accept) begin
                    wptr <= wptr_eff + 1'b1;
                    if (wr_last) begin
                        wfull <= 1'b1;
                    end
                end else begin
                    wptr <= wptr_eff;
                end
            end

            if (rd_ce) begin
                act_q <= win_hit && rvalid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer RAM: one write port and one registered read port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[{wsel, wptr_eff}] <= wr_index;
        end
    end

    // The read data holds between pixel strobes because it only loads on rd_ce.
    always_ff @(posedge clk) begin
        if (rd_ce) begin
            ram_q <= mem[{~wsel, raddr}];
        end
    end

    assign rd_index  = act_q ? ram_q : BLANK_IDX;
    assign rd_active = act_q;

endmodule
